mem_wb_arbiter: RTL and testbench
=================================

# mem_wb_arbiter

Two-master to one-slave pipelined Wishbone arbiter that shares a single-port Wishbone memory between the core's data port (master 0) and instruction-fetch port (master 1). It sits between the core's bus interfaces and the memory slave.

The granted master's bus signals pass through to the slave. The other master is stalled. The grant is held until the owner ends its cycle with no transfers outstanding.

## Interface
Parameters:
- `WIDTH`, 32, data width; sel width is `WIDTH/8`.
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unacknowledged transfers per grant (≥1).

Ports:
- `clk_i`  in  1  clock; everything is on the rising edge.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 bus controls.
- `m0_addr_i`  in  32  master 0 address.
- `m0_sel_i`  in  `WIDTH/8`  master 0 byte selects.
- `m0_wdata_i`  in  `WIDTH`  master 0 write data.
- `m0_rdata_o`  out  `WIDTH`  master 0 read data.
- `m0_ack_o`, `m0_err_o`, `m0_rty_o`, `m0_stall_o`  out  1 each  master 0 responses and stall.
- `m1_*`  same set of ports as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave bus controls.
- `s_addr_o`  out  32  slave address.
- `s_sel_o`  out  `WIDTH/8`  slave byte selects.
- `s_wdata_o`  out  `WIDTH`  slave write data.
- `s_rdata_i`  in  `WIDTH`  slave read data.
- `s_ack_i`, `s_err_i`, `s_rty_i`, `s_stall_i`  in  1 each  slave responses and stall.

## Operation
- **FSM states:** IDLE, GRANT0, GRANT1. Reset enters IDLE, clears the outstanding count to 0 and sets `last_q` to 1.
- **IDLE:**
  - Both `mX_stall_o` are 1.
  - All slave outputs are 0.
  - All master response outputs are 0; slave responses are discarded.
  - If any `mX_cyc_i` is high, move to the GRANTx of the winner at the next edge.
- **GRANTx:**
  - Slave outputs equal master x's inputs.
  - `mX_stall_o` = `s_stall_i | (count == MAX_OUTSTANDING)`.
  - Under that stall condition `s_stb_o` is forced to 0.
  - The other master's stall is 1 and its responses are 0.
  - `s_ack_i`, `s_err_i`, `s_rty_i` and `s_rdata_i` route to master x.
- **Outstanding counter**, width `$clog2(MAX_OUTSTANDING+1)`:
  - Increments on accept (`s_stb_o & !mX_stall_o`).
  - Decrements on `s_ack_i | s_err_i | s_rty_i`.
  - Accept and response in the same cycle leave it unchanged.
  - It never wraps, because accepts are blocked at MAX and responses never exceed accepts.
- **Release:**
  - GRANTx → IDLE when `mX_cyc_i` = 0 and count = 0.
  - `last_q` is set to x.
- **Abort:**
  - If `mX_cyc_i` drops while count > 0, go to IDLE and clear count to 0.
  - Late acks arrive while in IDLE and are dropped.
- **Handover:** there is always exactly one IDLE cycle between grants.
- **Arbitration:** see Configuration.

## Timing
- Slave outputs and master responses are combinational from the inputs and the registered state.
- The grant is registered, so the first request from IDLE costs one stall cycle.
- Example with the memory slave (ack one cycle after the strobe, no stall):
  - Cycle 0: request, stalled.
  - Cycle 1: accepted.
  - Cycle 2: ack.
- Back-to-back pipelined strobes sustain one transfer per cycle while the count is below MAX.
- Reset in mid-transfer: IDLE on the next edge. No response is forwarded in the cycle after reset, even if the slave acks.

## Configuration
- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** when both masters request in IDLE, grant the master ≠ `last_q`. A single requester always wins.
- **Undefined:** fixed priority, master 0 always wins a tie. `last_q` is still maintained but ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE, GRANT0, GRANT1).
  - `master_idx_t` (1 bit).
  - The constant `NUM_MASTERS = 2`.
- Sub-module `wb_outstanding_cnt`:
  - Inputs: `clk_i`, `rstn_i`, clear, inc, dec.
  - Outputs: `count`, `full`, `empty`.
  - Parameter: `MAX_OUTSTANDING`.

## Test plan
- **Single read:** m0 read of addr 0x10 from IDLE.
  - `m0_stall_o` = 1 at cycle 0 and 0 at cycle 1.
  - `s_stb_o` = 1 at cycle 1.
  - `m0_ack_o` with the memory data at cycle 2.
  - IDLE at cycle 3 once cyc drops.
- **Pipelined writes:** m1 issues 6 writes with `MAX_OUTSTANDING` = 4 and the slave acking 3 cycles late.
  - Stall asserts while count = 4.
  - All 6 acks return to m1 only.
  - The count ends at 0.
- **Simultaneous request:** both masters request in IDLE after reset.
  - m0 is granted in both builds.
  - On the second simultaneous request, m1 is granted with the macro and m0 without it.
- **Held grant:** m1 requests while m0 holds cyc with count > 0.
  - `m1_stall_o` stays 1 until m0 releases.
  - m1 is granted exactly 2 cycles after the release cycle.
- **Abort:** m0 drops cyc with 2 outstanding.
  - IDLE next cycle with count = 0.
  - The late `s_ack_i` reaches neither master.
- **Mid-transfer reset:** assert `rstn_i` = 0 with count = 3.
  - IDLE on the next edge.
  - All acks = 0 and both stalls = 1.
  - `s_cyc_o` = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master Wishbone memory arbiter.
package mem_arb_pkg;

    localparam int unsigned NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef logic [$clog2(NUM_MASTERS)-1:0] master_idx_t;

    function automatic arb_state_e grant_state(input master_idx_t idx);
        return (idx == 1'b0) ? GRANT0 : GRANT1;
    endfunction

endpackage

// File: rtl/wb_outstanding_cnt.sv
// wb_outstanding_cnt: saturating count of accepted-but-unacknowledged Wishbone transfers.
module wb_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rstn_i,
    input  logic                                     clear,
    input  logic                                     inc,
    input  logic                                     dec,
    output logic [$clog2(MAX_OUTSTANDING + 1)-1:0]   count,
    output logic                                     full,
    output logic                                     empty
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);

    // Simultaneous inc and dec cancel; the full/empty guards keep the count from wrapping.
    always_ff @(posedge clk_i) begin
        if (!rstn_i || clear) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/mem_wb_arbiter.sv
// mem_wb_arbiter: two-master pipelined Wishbone arbiter sharing one memory slave.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise master 0 wins ties.
module mem_wb_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,

    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    input  logic                 m0_we_i,
    input  logic [31:0]          m0_addr_i,
    input  logic [WIDTH/8-1:0]   m0_sel_i,
    input  logic [WIDTH-1:0]     m0_wdata_i,
    output logic [WIDTH-1:0]     m0_rdata_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    output logic                 m0_rty_o,
    output logic                 m0_stall_o,

    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    input  logic                 m1_we_i,
    input  logic [31:0]          m1_addr_i,
    input  logic [WIDTH/8-1:0]   m1_sel_i,
    input  logic [WIDTH-1:0]     m1_wdata_i,
    output logic [WIDTH-1:0]     m1_rdata_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic                 m1_rty_o,
    output logic                 m1_stall_o,

    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [31:0]          s_addr_o,
    output logic [WIDTH/8-1:0]   s_sel_o,
    output logic [WIDTH-1:0]     s_wdata_o,
    input  logic [WIDTH-1:0]     s_rdata_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_rty_i,
    input  logic                 s_stall_i
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e    state;
    master_idx_t   last_q;
    master_idx_t   winner;
    logic          own0, own1, own_cyc;
    logic          hold, rsp, accept, clear;
    logic          full, empty;
    logic [CW-1:0] count;
    logic          unused_sig;

    assign own0    = (state == GRANT0);
    assign own1    = (state == GRANT1);
    assign own_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign hold    = s_stall_i | full;
    assign rsp     = s_ack_i | s_err_i | s_rty_i;
    assign accept  = s_stb_o & ~hold;
    // Clearing whenever no owner holds cyc covers IDLE, release and abort alike.
    assign clear   = ~own_cyc;

    wb_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clear  (clear),
        .inc    (accept),
        .dec    (rsp & (own0 | own1)),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign winner     = (m0_cyc_i & m1_cyc_i) ? ~last_q : (m1_cyc_i & ~m0_cyc_i);
    assign unused_sig = ^count;
`else
    assign winner     = m1_cyc_i & ~m0_cyc_i;
    assign unused_sig = ^{count, last_q};
`endif

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state  <= IDLE;
            last_q <= 1'b1;
        end else begin
            case (state)
                IDLE:
                    if (m0_cyc_i | m1_cyc_i) state <= grant_state(winner);
                GRANT0:
                    if (!m0_cyc_i) begin
                        state  <= IDLE;
                        last_q <= 1'b0;
                    end
                GRANT1:
                    if (!m1_cyc_i) begin
                        state  <= IDLE;
                        last_q <= 1'b1;
                    end
                default:
                    state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_sel_o    = '0;
        s_wdata_o  = '0;
        m0_rdata_o = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_rdata_o = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        m1_stall_o = 1'b1;
        case (state)
            GRANT0: begin
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i & ~hold;
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_sel_o    = m0_sel_i;
                s_wdata_o  = m0_wdata_i;
                m0_rdata_o = s_rdata_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                m0_rty_o   = s_rty_i;
                m0_stall_o = hold;
            end
            GRANT1: begin
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i & ~hold;
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_sel_o    = m1_sel_i;
                s_wdata_o  = m1_wdata_i;
                m1_rdata_o = s_rdata_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                m1_rty_o   = s_rty_i;
                m1_stall_o = hold;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// tb_mem_wb_arbiter: directed scoreboard bench for mem_wb_arbiter with a latency-programmable memory slave.
module tb_mem_wb_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [3:0]  m0_sel = '0;
    logic [31:0] m0_rdata_o;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m0_stall_o;

    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] m1_rdata_o;
    logic        m1_ack_o, m1_err_o, m1_rty_o, m1_stall_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_rdata;
    logic        s_ack, s_err = 1'b0, s_rty = 1'b0, s_stall = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          mst;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_wb_arbiter #(
        .WIDTH           (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .m0_cyc_i   (m0_cyc),
        .m0_stb_i   (m0_stb),
        .m0_we_i    (m0_we),
        .m0_addr_i  (m0_addr),
        .m0_sel_i   (m0_sel),
        .m0_wdata_i (m0_wdata),
        .m0_rdata_o (m0_rdata_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m0_rty_o   (m0_rty_o),
        .m0_stall_o (m0_stall_o),
        .m1_cyc_i   (m1_cyc),
        .m1_stb_i   (m1_stb),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_sel_i   (m1_sel),
        .m1_wdata_i (m1_wdata),
        .m1_rdata_o (m1_rdata_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .m1_rty_o   (m1_rty_o),
        .m1_stall_o (m1_stall_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_sel_o    (s_sel_o),
        .s_wdata_o  (s_wdata_o),
        .s_rdata_i  (s_rdata),
        .s_ack_i    (s_ack),
        .s_err_i    (s_err),
        .s_rty_i    (s_rty),
        .s_stall_i  (s_stall)
    );

    // Memory slave: acks `lat` cycles after accept (lat=1 is the normal single-cycle memory).
    logic [31:0] mem [16];
    logic [3:0]  pv = '0;
    logic [31:0] pd [4];
    int          lat = 1;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 4; i++) pd[i] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            pv[i] <= pv[i+1];
            pd[i] <= pd[i+1];
        end
        pv[3] <= 1'b0;
        if (s_cyc_o && s_stb_o && !s_stall) begin
            pv[lat-1] <= 1'b1;
            pd[lat-1] <= s_we_o ? 32'h0 : mem[s_addr_o[5:2]];
            if (s_we_o) mem[s_addr_o[5:2]] <= s_wdata_o;
        end
    end

    assign s_ack   = pv[0];
    assign s_rdata = pv[0] ? pd[0] : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input bit m, input logic [31:0] d);
        exp_t e;
        e.mst  = m;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && sb.size() != 0; k++) cyc_edge();
        check(name, sb.size(), 0);
    endtask

    // Monitor: every master ack must match the oldest expected response.
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b expected no ack", m0_ack_o, m1_ack_o);
            end else begin
                mon_e = sb.pop_front();
                check("sb_master", {30'd0, m1_ack_o, m0_ack_o}, mon_e.mst ? 32'd2 : 32'd1);
                check("sb_rdata", mon_e.mst ? m1_rdata_o : m0_rdata_o, mon_e.data);
            end
        end
    end

    task automatic do_reset();
        rstn = 1'b0;
        cyc_edge();
        cyc_edge();
        @(negedge clk);
        check("rst_m0_stall", m0_stall_o, 1);
        check("rst_m1_stall", m1_stall_o, 1);
        check("rst_s_cyc", s_cyc_o, 0);
        cyc_edge();
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_full;
        int idx;
        bit acc;

        do_reset();

        // Single read from IDLE
        cyc_edge();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h10; m0_sel = 4'hF;
        sb_push(0, 32'hA000_0004);
        @(negedge clk);
        check("rd_c0_stall", m0_stall_o, 1);
        check("rd_c0_s_stb", s_stb_o, 0);
        cyc_edge();
        @(negedge clk);
        check("rd_c1_stall", m0_stall_o, 0);
        check("rd_c1_s_stb", s_stb_o, 1);
        check("rd_c1_s_addr", s_addr_o, 32'h10);
        cyc_edge();
        m0_stb = 0; m0_cyc = 0;
        @(negedge clk);
        check("rd_c2_ack", m0_ack_o, 1);
        cyc_edge();
        @(negedge clk);
        check("rd_c3_idle_stall", m0_stall_o, 1);
        check("rd_c3_s_cyc", s_cyc_o, 0);

        // Pipelined writes from m1, slave acking 3 cycles later than normal
        cyc_edge();
        lat = 4;
        m1_cyc = 1; m1_we = 1; m1_sel = 4'hF;
        for (int i = 0; i < 6; i++) sb_push(1, 32'h0);
        idx = 0;
        saw_full = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            m1_stb = 1; m1_addr = 32'h20 + 4 * idx; m1_wdata = 32'hC0DE_0000 + idx;
            @(negedge clk);
            if (dut.u_cnt.count == 3'd4) begin
                saw_full = 1;
                check("wr_full_stall", m1_stall_o, 1);
            end
            acc = !m1_stall_o;
            cyc_edge();
            if (acc) idx++;
        end
        m1_stb = 0;
        check("wr_issued", idx, 6);
        check("wr_saw_full", saw_full, 1);
        drain("wr_drain");
        @(negedge clk);
        check("wr_count_zero", dut.u_cnt.count, 0);
        cyc_edge();
        m1_cyc = 0; m1_we = 0;
        for (int i = 0; i < 6; i++) check("wr_mem", mem[8+i], 32'hC0DE_0000 + i);
        lat = 1;

        // Simultaneous requests
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        cyc_edge();
        @(negedge clk);
        check("tie1_m0_stall", m0_stall_o, 0);
        check("tie1_m1_stall", m1_stall_o, 1);
        cyc_edge();
        m0_cyc = 0; m1_cyc = 0;
        cyc_edge();
        m0_cyc = 1; m1_cyc = 1;
        cyc_edge();
        @(negedge clk);
        check("tie2_m0_stall", m0_stall_o, RR_EN ? 1 : 0);
        check("tie2_m1_stall", m1_stall_o, RR_EN ? 0 : 1);
        cyc_edge();
        m0_cyc = 0; m1_cyc = 0;
        cyc_edge();
        cyc_edge();

        // Held grant: m1 waits while m0 has an outstanding read
        lat = 4;
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h18;
        sb_push(0, 32'hA000_0006);
        sb_push(1, 32'hA000_0002);
        cyc_edge();
        cyc_edge();
        m0_stb = 0;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h08; m1_sel = 4'hF;
        for (int c = 2; c <= 7; c++) begin
            if (c == 6) m0_cyc = 0;
            if (c == 7) lat = 1;
            @(negedge clk);
            check("hold_m1_stall", m1_stall_o, 1);
            cyc_edge();
        end
        @(negedge clk);
        check("hold_m1_grant", m1_stall_o, 0);
        check("hold_s_addr", s_addr_o, 32'h08);
        cyc_edge();
        m1_stb = 0;
        drain("hold_drain");
        m1_cyc = 0;
        cyc_edge();

        // Abort with two reads outstanding
        lat = 4;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0C;
        cyc_edge();
        cyc_edge();
        m0_addr = 32'h10;
        cyc_edge();
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        check("abort_count2", dut.u_cnt.count, 2);
        cyc_edge();
        @(negedge clk);
        check("abort_count0", dut.u_cnt.count, 0);
        check("abort_m0_stall", m0_stall_o, 1);
        check("abort_s_cyc", s_cyc_o, 0);
        for (int c = 5; c <= 6; c++) begin
            cyc_edge();
            @(negedge clk);
            check("abort_late_ack", {30'd0, m1_ack_o, m0_ack_o}, 0);
        end
        cyc_edge();
        cyc_edge();

        // Reset with three reads outstanding
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h00;
        cyc_edge();
        cyc_edge();
        m1_addr = 32'h04;
        cyc_edge();
        m1_addr = 32'h08;
        cyc_edge();
        m1_stb = 0;
        rstn = 1'b0;
        @(negedge clk);
        check("mrst_count3", dut.u_cnt.count, 3);
        cyc_edge();
        @(negedge clk);
        check("mrst_acks", {30'd0, m1_ack_o, m0_ack_o}, 0);
        check("mrst_stalls", {30'd0, m1_stall_o, m0_stall_o}, 3);
        check("mrst_s_cyc", s_cyc_o, 0);
        check("mrst_count0", dut.u_cnt.count, 0);
        cyc_edge();
        rstn = 1'b1;
        m1_cyc = 0;
        for (int c = 0; c < 4; c++) cyc_edge();
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
